// File: rtl/register_bank.sv
// register_bank
//   Parametrised architectural register bank: NREGS identical registers of
//   WIDTH bits with three write sources (ALU full-width write, memory byte
//   stream, pointer increment/decrement) and a two-beat little-endian word
//   loader fed by a valid/ready byte stream.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   regs       all registers, register i at [i*WIDTH +: WIDTH]
//   mem_valid  byte beat offered
//   mem_ready  bank can accept a beat (low only while reset is high)
//   mem_sel    destination register for a beat
//   mem_mode   00 low byte, 01 high byte, 10 zero-extended byte, 11 word
//   mem_data   byte payload
//   mem_abort  discard a partially assembled word
//   busy       word load waiting for its high beat
//   alu_we     ALU full-width write enable
//   alu_sel    ALU destination register
//   alu_data   ALU write data
//   inc_en     pointer adjust enable
//   inc_sel    pointer register
//   inc_dir    0 = +PTR_STEP, 1 = -PTR_STEP
module register_bank #(
  parameter int NREGS    = 8,
  parameter int WIDTH    = 16,
  parameter int PTR_STEP = 2,
  parameter int SEL_W    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [NREGS*WIDTH-1:0] regs,
  input  logic                   mem_valid,
  output logic                   mem_ready,
  input  logic [SEL_W-1:0]       mem_sel,
  input  logic [1:0]             mem_mode,
  input  logic [7:0]             mem_data,
  input  logic                   mem_abort,
  output logic                   busy,
  input  logic                   alu_we,
  input  logic [SEL_W-1:0]       alu_sel,
  input  logic [WIDTH-1:0]       alu_data,
  input  logic                   inc_en,
  input  logic [SEL_W-1:0]       inc_sel,
  input  logic                   inc_dir
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HIGH = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(PTR_STEP);

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       lo_byte_r;
  logic [7:0]       lo_byte_next_s;
  logic [SEL_W-1:0] word_sel_r;
  logic [SEL_W-1:0] word_sel_next_s;
  logic             busy_r;
  logic             accept_s;

  // Memory write request produced by the loader: mem_op_s == 2'b11 marks a
  // word commit, the other codes are the byte modes.
  logic             mem_we_s;
  logic [SEL_W-1:0] mem_tgt_s;
  logic [1:0]       mem_op_s;

  logic [WIDTH-1:0] regs_r      [NREGS];
  logic [WIDTH-1:0] regs_next_s [NREGS];

  assign mem_ready = ~reset;
  assign accept_s  = mem_valid & mem_ready;
  assign busy      = busy_r;

  // Flatten the register array onto the output bus.
  for (genvar g = 0; g < NREGS; g++) begin : g_out
    assign regs[g*WIDTH +: WIDTH] = regs_r[g];
  end

  // Word-loader FSM next state and memory write request.
  always_comb begin
    state_next_s    = state_r;
    lo_byte_next_s  = lo_byte_r;
    word_sel_next_s = word_sel_r;
    mem_we_s        = 1'b0;
    mem_tgt_s       = mem_sel;
    mem_op_s        = mem_mode;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (mem_mode == 2'b11) begin
            // Low beat only latches; the register is untouched until the high beat.
            state_next_s    = HIGH;
            lo_byte_next_s  = mem_data;
            word_sel_next_s = mem_sel;
          end else begin
            mem_we_s = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      HIGH: begin
        // Abort beats any beat offered in the same cycle.
        if (mem_abort) begin
          state_next_s = IDLE;
        end else if (accept_s) begin
          state_next_s = IDLE;
          mem_we_s     = 1'b1;
          mem_tgt_s    = word_sel_r;
          mem_op_s     = 2'b11;
        end else begin
          state_next_s = HIGH;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Per-register next value; later assignments win (pointer < memory < ALU).
  always_comb begin
    logic [WIDTH-1:0] merged_v;
    for (int i = 0; i < NREGS; i++) begin
      regs_next_s[i] = regs_r[i];
      merged_v       = regs_r[i];
      case (mem_op_s)
        2'b00: merged_v[7:0] = mem_data;
        2'b01: merged_v[15:8] = mem_data;
        2'b10: begin
          merged_v      = '0;
          merged_v[7:0] = mem_data;
        end
        2'b11: begin
          merged_v       = '0;
          merged_v[15:0] = {mem_data, lo_byte_r};
        end
        default: merged_v = regs_r[i];
      endcase
      if (inc_en && (inc_sel == SEL_W'(i))) begin
        regs_next_s[i] = inc_dir ? (regs_r[i] - STEP) : (regs_r[i] + STEP);
      end else begin
        regs_next_s[i] = regs_r[i];
      end
      if (mem_we_s && (mem_tgt_s == SEL_W'(i))) begin
        regs_next_s[i] = merged_v;
      end else begin
        regs_next_s[i] = regs_next_s[i];
      end
      if (alu_we && (alu_sel == SEL_W'(i))) begin
        regs_next_s[i] = alu_data;
      end else begin
        regs_next_s[i] = regs_next_s[i];
      end
    end
  end

  // State, loader latches and register array.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      lo_byte_r  <= 8'h00;
      word_sel_r <= '0;
      busy_r     <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else begin
      state_r    <= state_next_s;
      lo_byte_r  <= lo_byte_next_s;
      word_sel_r <= word_sel_next_s;
      busy_r     <= (state_next_s == HIGH);
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= regs_next_s[i];
      end
    end
  end

endmodule

// File: tb/tb_register_bank.sv
// Testbench for register_bank: directed scenarios followed by random traffic.
// A driver applies one cycle of inputs at the falling edge, advances a
// behavioural model and queues the expected post-edge view; a monitor pops
// and compares shortly after every rising edge.
module tb_register_bank;

  localparam int NREGS = 8;
  localparam int WIDTH = 16;
  localparam int SEL_W = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NREGS*WIDTH-1:0] regs;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [SEL_W-1:0]       mem_sel;
  logic [1:0]             mem_mode;
  logic [7:0]             mem_data;
  logic                   mem_abort;
  logic                   busy;
  logic                   alu_we;
  logic [SEL_W-1:0]       alu_sel;
  logic [WIDTH-1:0]       alu_data;
  logic                   inc_en;
  logic [SEL_W-1:0]       inc_sel;
  logic                   inc_dir;

  register_bank #(.NREGS(NREGS), .WIDTH(WIDTH), .PTR_STEP(2)) dut (
    .clk(clk), .reset(reset), .regs(regs),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_sel(mem_sel),
    .mem_mode(mem_mode), .mem_data(mem_data), .mem_abort(mem_abort),
    .busy(busy), .alu_we(alu_we), .alu_sel(alu_sel), .alu_data(alu_data),
    .inc_en(inc_en), .inc_sel(inc_sel), .inc_dir(inc_dir)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                  name;
    logic [NREGS*WIDTH-1:0] regs;
    logic                   busy;
    logic                   ready;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  // Reference model state
  logic [15:0] m_regs [NREGS];
  bit          m_pend;
  logic [7:0]  m_lo;
  int          m_wsel;

  task automatic drive(input string nm, input bit r, input bit mv, input int msel,
                       input int mmode, input int mdata, input bit ma, input bit awe,
                       input int asel, input int adata, input bit ie, input int isel,
                       input bit idir);
    exp_t        e;
    logic [15:0] nxt [NREGS];
    bit          mem_hit;
    int          mem_t;
    logic [15:0] mem_v;
    @(negedge clk);
    reset = r; mem_valid = mv; mem_sel = SEL_W'(msel); mem_mode = 2'(mmode);
    mem_data = 8'(mdata); mem_abort = ma; alu_we = awe; alu_sel = SEL_W'(asel);
    alu_data = 16'(adata); inc_en = ie; inc_sel = SEL_W'(isel); inc_dir = idir;
    if (r) begin
      for (int i = 0; i < NREGS; i++) m_regs[i] = 16'h0000;
      m_pend = 1'b0; m_lo = 8'h00; m_wsel = 0;
    end else begin
      for (int i = 0; i < NREGS; i++) nxt[i] = m_regs[i];
      mem_hit = 1'b0; mem_t = msel; mem_v = 16'h0000;
      if (m_pend) begin
        if (ma) m_pend = 1'b0;
        else if (mv) begin
          mem_hit = 1'b1; mem_t = m_wsel;
          mem_v = 16'(mdata) * 16'd256 + 16'(m_lo);
          m_pend = 1'b0;
        end
      end else if (mv) begin
        case (mmode)
          0: begin mem_hit = 1'b1; mem_v = (m_regs[msel] & 16'hFF00) | 16'(mdata); end
          1: begin mem_hit = 1'b1; mem_v = (m_regs[msel] & 16'h00FF) | (16'(mdata) << 8); end
          2: begin mem_hit = 1'b1; mem_v = 16'(mdata); end
          default: begin m_pend = 1'b1; m_lo = 8'(mdata); m_wsel = msel; end
        endcase
      end
      if (ie) nxt[isel] = idir ? m_regs[isel] - 16'd2 : m_regs[isel] + 16'd2;
      if (mem_hit) nxt[mem_t] = mem_v;
      if (awe) nxt[asel] = 16'(adata);
      for (int i = 0; i < NREGS; i++) m_regs[i] = nxt[i];
    end
    e.name  = nm;
    e.busy  = m_pend;
    e.ready = !r;
    for (int i = 0; i < NREGS; i++) e.regs[i*WIDTH +: WIDTH] = m_regs[i];
    q.push_back(e);
  endtask

  task automatic idle(input string nm);
    drive(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic alu(input string nm, input int sel, input int data);
    drive(nm, 0, 0, 0, 0, 0, 0, 1, sel, data, 0, 0, 0);
  endtask

  task automatic beat(input string nm, input int sel, input int mode, input int data);
    drive(nm, 0, 1, sel, mode, data, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT view after each rising edge with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (regs !== e.regs) begin
          failed++;
          $display("FAIL %s regs: got %h expected %h", e.name, regs, e.regs);
        end
        tests++;
        if (busy !== e.busy) begin
          failed++;
          $display("FAIL %s busy: got %0b expected %0b", e.name, busy, e.busy);
        end
        tests++;
        if (mem_ready !== e.ready) begin
          failed++;
          $display("FAIL %s mem_ready: got %0b expected %0b", e.name, mem_ready, e.ready);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; mem_valid = 1'b0; mem_sel = '0; mem_mode = 2'b00; mem_data = 8'h00;
    mem_abort = 1'b0; alu_we = 1'b0; alu_sel = '0; alu_data = 16'h0000;
    inc_en = 1'b0; inc_sel = '0; inc_dir = 1'b0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 16'h0000;
    m_pend = 1'b0; m_lo = 8'h00; m_wsel = 0;

    // Reset with a beat offered to r1: must be refused
    drive("reset_beat", 1, 1, 1, 2, 8'h55, 0, 0, 0, 0, 0, 0, 0);
    idle("after_reset");

    // Byte modes on r3
    alu("r3_preload", 3, 16'hAAAA);
    beat("mode00", 3, 0, 8'h12);
    beat("mode01", 3, 1, 8'h34);
    beat("mode10", 3, 2, 8'h56);

    // Word load on r5 with a gap; high beat carries ignored sel/mode
    alu("r5_preload", 5, 16'h1111);
    beat("word_lo", 5, 3, 8'h78);
    idle("word_gap1"); idle("word_gap2"); idle("word_gap3");
    beat("word_hi", 0, 0, 8'h9A);

    // Abort mid-word, abort in IDLE, abort beating a same-cycle beat
    alu("r2_preload", 2, 16'h2222);
    beat("abort_lo", 2, 3, 8'hCD);
    drive("abort", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    drive("abort_idle", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    beat("abort2_lo", 2, 3, 8'hCD);
    drive("abort_with_beat", 0, 1, 2, 0, 8'hEE, 1, 0, 0, 0, 0, 0, 0);

    // Reset while HIGH, then a fresh word
    beat("rst_lo", 2, 3, 8'hCD);
    drive("rst_in_high", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    beat("post_rst_lo", 1, 3, 8'h01);
    beat("post_rst_hi", 6, 1, 8'h02);

    // Pointer wrap on r6
    drive("ptr_dec_wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 1);
    alu("r6_ffff", 6, 16'hFFFF);
    drive("ptr_inc_wrap", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, 0);

    // Collisions
    drive("collide_r4", 0, 1, 4, 0, 8'h77, 0, 1, 4, 16'hBEEF, 1, 4, 0);
    alu("r7_preload", 7, 16'h1000);
    beat("r4_word_lo", 4, 3, 8'h34);
    drive("r4_commit_r7_inc", 0, 1, 0, 0, 8'h12, 0, 0, 0, 0, 1, 7, 1);
    drive("mem_vs_ptr_r4", 0, 1, 4, 1, 8'hAB, 0, 0, 0, 0, 1, 4, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive("random", ($urandom_range(39) == 0), $urandom_range(1), $urandom_range(7),
            $urandom_range(3), $urandom_range(255), ($urandom_range(7) == 0),
            ($urandom_range(3) == 0), $urandom_range(7), $urandom_range(65535),
            ($urandom_range(2) == 0), $urandom_range(7), $urandom_range(1));
    end
    idle("drain");

    repeat (3) @(posedge clk);
    #3;
    tests++;
    if (q.size() != 0) begin
      failed++;
      $display("FAIL queue_drain: got %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
